// File: rtl/alu_cmd_sequencer.sv
// Command FIFO + issue/capture FSM wrapped around the registered ALU core.
// Define ALU_SEQ_ILLEGAL_OP_EN to answer opcodes above 4'b1010 locally with rsp_err instead of issuing them.
module alu_cmd_sequencer #(
    parameter int DEPTH       = 4,
    parameter int TAG_W       = 4,
    parameter int HOLD_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_opcode,
    input  logic [15:0]      cmd_a,
    input  logic [15:0]      cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [15:0]      alu_operand_a,
    output logic [15:0]      alu_operand_b,
    output logic [3:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy,
    output logic [15:0]      rsp_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 36 + TAG_W;
    localparam int CW = $clog2(HOLD_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, HOLD, CAPT, RESP} state_t;

    state_t          state, state_next;
    logic [EW-1:0]   mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, push, pop, head_illegal;
    logic [3:0]      head_op;
    logic [15:0]     head_a, head_b;
    logic [TAG_W-1:0] head_tag, tag_q;
    logic [CW-1:0]   hold_cnt;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign {head_op, head_a, head_b, head_tag} = mem[rd_ptr[AW-1:0]];
    assign busy      = !empty || (state != IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {cmd_opcode, cmd_a, cmd_b, cmd_tag};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // A pop from RESP on the handshake edge reloads directly, skipping IDLE.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = head_illegal ? RESP : HOLD;
                end
            end
            HOLD: begin
                if (hold_cnt == CW'(1)) state_next = CAPT;
            end
            CAPT: state_next = RESP;
            RESP: begin
                if (rsp_valid && rsp_ready) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        state_next = head_illegal ? RESP : HOLD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
        endcase
    end

    // Divide results emerge from the ALU one edge later, so divides hold one cycle longer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_opcode    <= '0;
            tag_q         <= '0;
            hold_cnt      <= '0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_tag       <= '0;
            rsp_count     <= '0;
        end else begin
            if (pop && !head_illegal) begin
                alu_operand_a <= head_a;
                alu_operand_b <= head_b;
                alu_opcode    <= head_op;
                hold_cnt      <= CW'(HOLD_CYCLES) + {{(CW-1){1'b0}}, head_op == 4'b0011};
            end else if (state == HOLD) begin
                hold_cnt <= hold_cnt - CW'(1);
            end
            if (pop) tag_q <= head_tag;
            if (state == CAPT) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_tag    <= tag_q;
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                rsp_count <= rsp_count + 16'd1;
            end
            if (pop && head_illegal) begin
                rsp_valid  <= 1'b1;
                rsp_result <= '0;
                rsp_tag    <= head_tag;
            end
        end
    end

`ifdef ALU_SEQ_ILLEGAL_OP_EN
    assign head_illegal = (head_op > 4'b1010);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)    rsp_err <= 1'b0;
        else if (pop) rsp_err <= head_illegal;
    end
`else
    assign head_illegal = 1'b0;
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Command front-end and result back-end wrapped around the ALU core. It accepts {opcode, operandA, operandB, tag} commands over a valid/ready handshake and buffers them in a FIFO. It drives them one at a time onto the ALU inputs, holding each stable for the ALU's internal settle time, then captures the ALU's registered 32-bit result. The result is presented, tagged, to a downstream consumer over a second valid/ready handshake.

Parameters:
DEPTH, 4, command FIFO entries; power of 2, >= 2
TAG_W, 4, width of the command tag carried to the response
HOLD_CYCLES, 1, cycles the operands are held between load and the ALU sampling edge; >= 1

Ports:
clk  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high; shared with the ALU core
cmd_valid  in  1  command present
cmd_ready  out  1  FIFO can accept a command
cmd_opcode  in  4  ALU opcode (0000 add … 1010 decrement)
cmd_a  in  16  signed operandA
cmd_b  in  16  signed operandB
cmd_tag  in  TAG_W  opaque id, returned with the result
alu_operand_a  out  16  to ALU operandA (registered)
alu_operand_b  out  16  to ALU operandB (registered)
alu_opcode  out  4  to ALU opcode (registered)
alu_result  in  32  from ALU result (registered in the ALU)
rsp_valid  out  1  response present
rsp_ready  in  1  consumer accepts the response
rsp_result  out  32  signed ALU result
rsp_tag  out  TAG_W  tag of the originating command
rsp_err  out  1  illegal-opcode flag (see Optional Feature)
busy  out  1  FIFO non-empty or FSM not IDLE
rsp_count  out  16  responses handed off; wraps 0xFFFF->0

Behaviour:
- Reset (async, active-high):
  - FIFO is emptied and the FSM goes to IDLE.
  - All outputs are 0: alu_* = 0, rsp_valid = 0, rsp_result = 0, rsp_tag = 0, rsp_err = 0, rsp_count = 0, busy = 0.
  - After reset, cmd_ready = 1.
- Command push: occurs on a posedge with cmd_valid & cmd_ready.
- cmd_ready = !full. There is no bypass, so a full FIFO does not accept a push even on a cycle where it pops.
- FSM states: IDLE, HOLD, CAPT, RESP.
- IDLE:
  - If the FIFO is non-empty, the next edge pops the head into alu_operand_a, alu_operand_b, alu_opcode and an internal tag register.
  - hold_cnt is loaded with HOLD_CYCLES, plus 1 when opcode = 4'b0011 (divide, whose result lags one extra ALU edge).
  - Next state: HOLD.
- HOLD:
  - hold_cnt decrements on each edge.
  - The edge where hold_cnt == 1 is the ALU sampling edge; next state is CAPT.
  - alu_* stay stable throughout.
- CAPT:
  - On the next edge: rsp_result <= alu_result, rsp_tag <= tag, rsp_valid <= 1.
  - Next state: RESP.
- RESP:
  - rsp_* hold until rsp_valid & rsp_ready on an edge. On that edge rsp_valid <= 0 and rsp_count increments.
  - On the same edge, if the FIFO is non-empty, the head is popped and loaded directly, going to HOLD without passing through IDLE. Otherwise next state is IDLE.
- alu_* keep their last values while idle; they are never cleared except by reset.
- Latency (HOLD_CYCLES = 1, non-divide, empty idle unit): command accepted at edge E0 → loaded at E1 → ALU samples at E2 → rsp_valid high after E3.
  - Divide: rsp_valid high after E4.
  - Each extra hold cycle adds 1.
- Ordering: strictly FIFO, one command in flight.
- Boundaries:
  - FIFO pointers are log2(DEPTH)+1 bits; full and empty are decoded from the MSB difference.
  - When full, a push is blocked and cmd_ready = 0.
  - Pop never occurs when empty.
  - Reset mid-operation drops the in-flight command and all queued commands; no response is emitted for them.
  - Opcodes 1011–1111 are issued unchanged (the ALU returns 0) unless the Optional Feature is enabled.

Optional Feature:
Macro: ALU_SEQ_ILLEGAL_OP_EN.
- Defined: a popped opcode > 4'b1010 is not driven to the ALU; alu_* retain their previous values. The FSM goes straight to RESP on the pop edge with rsp_result = 0, rsp_err = 1, rsp_tag = that command's tag. Latency is 1 edge after the pop.
- Undefined: no check; rsp_err is tied to 0.

Test Plan:
1. DEPTH = 4, HOLD_CYCLES = 1, rsp_ready = 1. Push add a = -10, b = -11, tag = 3 → rsp_result = 0xFFFFFFEB (-21), rsp_tag = 3, rsp_valid rises 3 edges after acceptance, rsp_count = 1.
2. rsp_ready = 0. Push 6 commands (add 1+1 … 6+6, tags 0–5) → 1 in flight + 4 queued; cmd_ready = 0 with the 6th pending. Raise rsp_ready → responses 2, 4, 6, 8, 10, 12 in tag order 0–5; rsp_count = 6; busy falls after the last handshake.
3. Divide a = 25, b = 5 → rsp_result = 5, rsp_valid 4 edges after acceptance. Back-to-back sub a = -15, b = 7 → -22, with no stale divide value.
4. HOLD_CYCLES = 4, multiply a = 10, b = 3 → rsp_result = 30; alu_operand_a/alu_operand_b unchanged for 4 cycles after load.
5. Assert reset while in HOLD with 3 commands queued → all outputs 0, cmd_ready = 1, busy = 0, no response after reset release. A fresh increment of 45 → 46.
6. With ALU_SEQ_ILLEGAL_OP_EN defined, opcode 4'b1100, tag = 9 → rsp_err = 1, rsp_result = 0, rsp_tag = 9, alu_opcode unchanged. The following XOR a = 10, b = -1 → -11, rsp_err = 0.
